rx_fifo_reader: RTL and testbench

Receive-side counterpart of the button-driven FIFO transmitter path. The block deserialises an asynchronous 8N1 serial line into bytes and buffers them in an internal FIFO. A button press pops one byte to a registered output for display. It sits at the board's receive pin and feeds LEDs or a seven-segment driver.

---
 rtl/rx_fifo_reader.sv | 234 +++++++++++++++++++++++
 tb/tb_rx_fifo_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo_reader.sv
// rx_fifo_reader: 8N1 serial receiver feeding a circular FIFO, popped one byte per button press.
// Define RX_PARITY_EN for even-parity frames, which adds a PARITY state and the parity_err_o port.
module rx_fifo_reader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 4
) (
    input  logic              clk100_i,
    input  logic              rstn_i,
    input  logic              rx_i,
    input  logic              btn_i,
    output logic [7:0]        data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
`ifdef RX_PARITY_EN
    output logic              parity_err_o,
`endif
    output logic              frame_err_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;
`ifdef RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd5;
`endif

    logic rxMeta_q, rxSync_q;
    logic btnMeta_q, btnSync_q, btnDly_q, popPulse_q;

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rxMeta_q   <= 1'b1;
            rxSync_q   <= 1'b1;
            btnMeta_q  <= 1'b0;
            btnSync_q  <= 1'b0;
            btnDly_q   <= 1'b0;
            popPulse_q <= 1'b0;
        end else begin
            rxMeta_q   <= rx_i;
            rxSync_q   <= rxMeta_q;
            btnMeta_q  <= btn_i;
            btnSync_q  <= btnMeta_q;
            btnDly_q   <= btnSync_q;
            popPulse_q <= btnSync_q & ~btnDly_q;
        end
    end

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             frameErr_q, frameErr_d;
    logic             push;
    logic             tick;
`ifdef RX_PARITY_EN
    logic             parityBad_q, parityBad_d;
    logic             parityErr_q, parityErr_d;
`endif

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitIdx_d   = bitIdx_q;
        shreg_d    = shreg_q;
        frameErr_d = frameErr_q;
        push       = 1'b0;
`ifdef RX_PARITY_EN
        parityBad_d = parityBad_q;
        parityErr_d = parityErr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxSync_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_BIT;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxSync_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DATA;
                    cnt_d    = FULL_BIT;
                    bitIdx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shreg_d[bitIdx_q] = rxSync_q;
                    cnt_d    = FULL_BIT;
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    parityBad_d = ^{shreg_q, rxSync_q};
                    cnt_d       = FULL_BIT;
                    state_d     = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
`ifdef RX_PARITY_EN
                    parityErr_d = parityErr_q | parityBad_q;
`endif
                    if (rxSync_q) begin
`ifdef RX_PARITY_EN
                        push = ~parityBad_q;
`else
                        push = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = S_WAIT_HIGH;
                    end
                end
            end
            // A stuck-low line after a bad stop bit must not look like a fresh start bit.
            S_WAIT_HIGH: begin
                if (rxSync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= 3'd0;
            shreg_q    <= 8'h00;
            frameErr_q <= 1'b0;
`ifdef RX_PARITY_EN
            parityBad_q <= 1'b0;
            parityErr_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            shreg_q    <= shreg_d;
            frameErr_q <= frameErr_d;
`ifdef RX_PARITY_EN
            parityBad_q <= parityBad_d;
            parityErr_q <= parityErr_d;
`endif
        end
    end

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wrPtr_q, rdPtr_q;
    logic [ADDR_W:0]   count_q;
    logic [7:0]        data_q;
    logic              overflow_q;
    logic              doPop, doPush;

    // A same-cycle pop frees the slot a push into a full FIFO needs.
    assign doPop  = popPulse_q && (count_q != '0);
    assign doPush = push && ((count_q != DEPTH_CNT) || doPop);

    always_ff @(posedge clk100_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= shreg_q;
        end
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            data_q     <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
                data_q  <= mem_q[rdPtr_q];
            end
            if (push && !doPush) begin
                overflow_q <= 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o      = data_q;
    assign level_o     = count_q;
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == DEPTH_CNT);
    assign overflow_o  = overflow_q;
    assign frame_err_o = frameErr_q;
`ifdef RX_PARITY_EN
    assign parity_err_o = parityErr_q;
`endif

endmodule

// File: tb/tb_rx_fifo_reader.sv
// Self-checking bench for rx_fifo_reader: a queue-based model checked every cycle, plus literal pins.
// Build with RX_PARITY_EN defined to also exercise the parity frames.
module tb_rx_fifo_reader;
    localparam int CPB   = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clock = 1'b0;
    logic        rstn;
    logic        rx;
    logic        btn;
    logic [7:0]  dataO;
    logic        emptyO;
    logic        fullO;
    logic [AW:0] levelO;
    logic        overflowO;
    logic        frameErrO;
`ifdef RX_PARITY_EN
    logic        parityErrO;
`endif

    int passCount  = 0;
    int checkCount = 0;
    bit checkEn    = 1'b0;

    logic [7:0] mQ[$];
    logic [7:0] mData;
    bit         mOverflow;
    bit         mFrameErr;
    bit         mParityErr;

    rx_fifo_reader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(AW)
    ) dut (
        .clk100_i(clock),
        .rstn_i(rstn),
        .rx_i(rx),
        .btn_i(btn),
        .data_o(dataO),
        .empty_o(emptyO),
        .full_o(fullO),
        .level_o(levelO),
        .overflow_o(overflowO),
`ifdef RX_PARITY_EN
        .parity_err_o(parityErrO),
`endif
        .frame_err_o(frameErrO)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        mQ.delete();
        mData      = 8'h00;
        mOverflow  = 1'b0;
        mFrameErr  = 1'b0;
        mParityErr = 1'b0;
    endfunction

    function automatic void modelPop();
        if (mQ.size() > 0) begin
            mData = mQ.pop_front();
        end
    endfunction

    function automatic void modelPush(input logic [7:0] b);
        if (mQ.size() < DEPTH) begin
            mQ.push_back(b);
        end else begin
            mOverflow = 1'b1;
        end
    endfunction

    // Every cycle the model holds the state the outputs must show after the latest edge.
    always @(posedge clock) begin
        #1;
        if (checkEn) begin
            checkOutput("cyc_data", dataO, mData);
            checkOutput("cyc_empty", emptyO, (mQ.size() == 0));
            checkOutput("cyc_full", fullO, (mQ.size() == DEPTH));
            checkOutput("cyc_level", levelO, mQ.size());
            checkOutput("cyc_overflow", overflowO, mOverflow);
            checkOutput("cyc_frame_err", frameErrO, mFrameErr);
`ifdef RX_PARITY_EN
            checkOutput("cyc_parity_err", parityErrO, mParityErr);
`endif
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // The stop sample lands 10 cycles after the stop bit is driven, so the result is visible at that edge.
    task automatic sendFrame(input logic [7:0] b, input bit stopBit, input bit alignPop, input bit parityFlip);
        bit parityBad;
        parityBad = 1'b0;
        for (int i = 0; i < NBITS - 1; i++) begin
            if (i == 0) begin
                rx = 1'b0;
            end else if (i <= 8) begin
                rx = b[i-1];
            end else begin
                rx = (^b) ^ parityFlip;
                parityBad = parityFlip;
            end
            repeat (CPB) @(negedge clock);
        end
        rx = stopBit;
        repeat (7) @(negedge clock);
        if (alignPop) begin
            btn = 1'b1;
        end
        repeat (3) @(negedge clock);
        if (alignPop) begin
            modelPop();
        end
        if (!stopBit) begin
            mFrameErr = 1'b1;
        end
        if (parityBad) begin
            mParityErr = 1'b1;
        end
        if (stopBit && !parityBad) begin
            modelPush(b);
        end
        repeat (CPB - 10) @(negedge clock);
        btn = 1'b0;
    endtask

    task automatic pressBtn();
        btn = 1'b1;
        repeat (3) @(negedge clock);
        modelPop();
        repeat (3) @(negedge clock);
        btn = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic applyStimulus();
        rstn = 1'b1;
        rx   = 1'b1;
        btn  = 1'b0;
        modelReset();
        #2 rstn = 1'b0;
        idleCycles(3);
        checkEn = 1'b1;
        checkOutput("rst_data", dataO, 8'h00);
        checkOutput("rst_empty", emptyO, 1'b1);
        checkOutput("rst_full", fullO, 1'b0);
        checkOutput("rst_level", levelO, 0);
        checkOutput("rst_overflow", overflowO, 1'b0);
        checkOutput("rst_frame_err", frameErrO, 1'b0);
        rstn = 1'b1;
        idleCycles(5);

        $display("[TB] single byte 0xA5");
        sendFrame(8'hA5, 1'b1, 1'b0, 1'b0);
        checkOutput("a5_level", levelO, 1);
        checkOutput("a5_empty", emptyO, 1'b0);
        pressBtn();
        checkOutput("a5_data", dataO, 8'hA5);
        checkOutput("a5_empty_after_pop", emptyO, 1'b1);

        $display("[TB] pop aligned with push into a full FIFO");
        sendFrame(8'h11, 1'b1, 1'b0, 1'b0);
        sendFrame(8'h22, 1'b1, 1'b0, 1'b0);
        sendFrame(8'h33, 1'b1, 1'b0, 1'b0);
        sendFrame(8'h44, 1'b1, 1'b0, 1'b0);
        checkOutput("align_full_before", fullO, 1'b1);
        sendFrame(8'h55, 1'b1, 1'b1, 1'b0);
        idleCycles(6);
        checkOutput("align_level", levelO, 4);
        checkOutput("align_overflow", overflowO, 1'b0);
        checkOutput("align_data", dataO, 8'h11);
        for (int i = 0; i < 4; i++) begin
            pressBtn();
        end
        checkOutput("align_last_data", dataO, 8'h55);

        $display("[TB] overflow on fifth byte");
        for (int i = 1; i <= 5; i++) begin
            sendFrame(8'(i), 1'b1, 1'b0, 1'b0);
            if (i == 4) begin
                checkOutput("ovf_full_after_4", fullO, 1'b1);
            end
        end
        checkOutput("ovf_flag", overflowO, 1'b1);
        checkOutput("ovf_level", levelO, 4);
        pressBtn();
        checkOutput("ovf_pop1", dataO, 8'h01);
        pressBtn();
        checkOutput("ovf_pop2", dataO, 8'h02);
        pressBtn();
        checkOutput("ovf_pop3", dataO, 8'h03);
        pressBtn();
        checkOutput("ovf_pop4", dataO, 8'h04);
        checkOutput("ovf_empty", emptyO, 1'b1);
        pressBtn();
        checkOutput("ovf_pop_empty_holds", dataO, 8'h04);

        $display("[TB] bad stop bit with line held low");
        sendFrame(8'h55, 1'b0, 1'b0, 1'b0);
        idleCycles(2 * CPB);
        checkOutput("ferr_flag", frameErrO, 1'b1);
        checkOutput("ferr_level", levelO, 0);
        rx = 1'b1;
        idleCycles(20);
        sendFrame(8'h3C, 1'b1, 1'b0, 1'b0);
        pressBtn();
        checkOutput("ferr_next_byte", dataO, 8'h3C);

        $display("[TB] short glitch on idle line");
        rx = 1'b0;
        idleCycles(4);
        rx = 1'b1;
        idleCycles(3 * CPB);
        checkOutput("glitch_level", levelO, 0);

        $display("[TB] reset in the middle of a frame");
        sendFrame(8'h99, 1'b1, 1'b0, 1'b0);
        rx = 1'b0;
        idleCycles(CPB);
        rx = 1'b1;
        idleCycles(CPB);
        rx = 1'b0;
        idleCycles(CPB + 5);
        rstn = 1'b0;
        rx   = 1'b1;
        modelReset();
        idleCycles(3);
        checkOutput("midrst_data", dataO, 8'h00);
        checkOutput("midrst_level", levelO, 0);
        checkOutput("midrst_overflow", overflowO, 1'b0);
        checkOutput("midrst_frame_err", frameErrO, 1'b0);
        rstn = 1'b1;
        idleCycles(10);
        sendFrame(8'h7E, 1'b1, 1'b0, 1'b0);
        checkOutput("midrst_level_after", levelO, 1);
        pressBtn();
        checkOutput("midrst_data_after", dataO, 8'h7E);

`ifdef RX_PARITY_EN
        $display("[TB] parity frames");
        sendFrame(8'h03, 1'b1, 1'b0, 1'b1);
        checkOutput("par_err_flag", parityErrO, 1'b1);
        checkOutput("par_err_level", levelO, 0);
        sendFrame(8'h03, 1'b1, 1'b0, 1'b0);
        checkOutput("par_ok_level", levelO, 1);
`endif
        idleCycles(5);
    endtask

    initial begin
        applyStimulus();
        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
